// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer and a registered in_ready_o.
// Defining PIPE_STAGE_SKID_BUBBLE_CNT_EN adds a saturating bubble/stall counter (cnt_clr_i, bubble_cnt_o).
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_SKID_BUBBLE_CNT_EN
    ,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    generate
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("CNT_W must be at least 1");
        end
    endgenerate
    // out_ctrl_o is the main ctrl register; it is cleared whenever the stage goes empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            out_ctrl_o  <= '0;
            out_data_o  <= '0;
            skid_ctrl   <= '0;
            skid_data   <= '0;
        end else if (flush_i) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            out_ctrl_o  <= '0;
            skid_ctrl   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid_i) begin
                        state       <= ONE;
                        out_valid_o <= 1'b1;
                        out_ctrl_o  <= in_ctrl_i;
                        out_data_o  <= in_data_i;
                    end
                end
                ONE: begin
                    if (out_ready_i && in_valid_i) begin
                        out_ctrl_o <= in_ctrl_i;
                        out_data_o <= in_data_i;
                    end else if (out_ready_i) begin
                        state       <= EMPTY;
                        out_valid_o <= 1'b0;
                        out_ctrl_o  <= '0;
                    end else if (in_valid_i) begin
                        state      <= TWO;
                        in_ready_o <= 1'b0;
                        skid_ctrl  <= in_ctrl_i;
                        skid_data  <= in_data_i;
                    end
                end
                TWO: begin
                    if (out_ready_i) begin
                        state      <= ONE;
                        in_ready_o <= 1'b1;
                        out_ctrl_o <= skid_ctrl;
                        out_data_o <= skid_data;
                        skid_ctrl  <= '0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    out_ctrl_o  <= '0;
                end
            endcase
        end
    end
`ifdef PIPE_STAGE_SKID_BUBBLE_CNT_EN
    // counts cycles where nothing leaves the stage: empty or stalled by downstream
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            bubble_cnt_o <= '0;
        else if (cnt_clr_i)
            bubble_cnt_o <= '0;
        else if ((!out_valid_o || !out_ready_i) && bubble_cnt_o != '1)
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vector table plus hand sequences for async reset and the optional bubble counter.
module tb_pipe_stage_skid;
`ifdef PIPE_STAGE_SKID_BUBBLE_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  in_ctrl_i;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_ctrl_o;
    logic [31:0] out_data_o;
`ifdef PIPE_STAGE_SKID_BUBBLE_CNT_EN
    logic                cnt_clr_i;
    logic [TB_CNT_W-1:0] bubble_cnt_o;
`endif
    int passed = 0;
    int total  = 0;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CNT_W(TB_CNT_W)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_ctrl_i(in_ctrl_i),
        .in_data_i(in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o),
        .out_data_o(out_data_o)
`ifdef PIPE_STAGE_SKID_BUBBLE_CNT_EN
        ,
        .cnt_clr_i(cnt_clr_i),
        .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [7:0]  ictrl;
        logic [31:0] idata;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [7:0]  e_ctrl;
        logic [31:0] e_data;
    } vec_t;

    localparam int NV = 21;
    vec_t v [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [7:0] c, input logic [31:0] d, input logic ordy);
        flush_i     = fl;
        in_valid_i  = iv;
        in_ctrl_i   = c;
        in_data_i   = d;
        out_ready_i = ordy;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic ir, input logic [7:0] c, input logic [31:0] d);
        chk({tag, ".out_valid"}, {31'b0, out_valid_o}, {31'b0, ov});
        chk({tag, ".in_ready"},  {31'b0, in_ready_o},  {31'b0, ir});
        chk({tag, ".out_ctrl"},  {24'b0, out_ctrl_o},  {24'b0, c});
        chk({tag, ".out_data"},  out_data_o, d);
    endtask

    initial begin
        //          flush iv ctrl   data    ordy  ov  ir  ctrl   data
        v[0]  = '{1'b0, 1'b1, 8'h11, 32'h1,  1'b1, 1'b1, 1'b1, 8'h11, 32'h1};
        v[1]  = '{1'b0, 1'b1, 8'h12, 32'h2,  1'b1, 1'b1, 1'b1, 8'h12, 32'h2};
        v[2]  = '{1'b0, 1'b1, 8'h13, 32'h3,  1'b1, 1'b1, 1'b1, 8'h13, 32'h3};
        v[3]  = '{1'b0, 1'b1, 8'h14, 32'h4,  1'b1, 1'b1, 1'b1, 8'h14, 32'h4};
        v[4]  = '{1'b0, 1'b1, 8'h15, 32'h5,  1'b1, 1'b1, 1'b1, 8'h15, 32'h5};
        v[5]  = '{1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 1'b0, 1'b1, 8'h00, 32'h5};
        v[6]  = '{1'b0, 1'b1, 8'hA1, 32'hA,  1'b0, 1'b1, 1'b1, 8'hA1, 32'hA};
        v[7]  = '{1'b0, 1'b1, 8'hB2, 32'hB,  1'b0, 1'b1, 1'b0, 8'hA1, 32'hA};
        v[8]  = '{1'b0, 1'b1, 8'h77, 32'h77, 1'b0, 1'b1, 1'b0, 8'hA1, 32'hA};
        v[9]  = '{1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 1'b1, 1'b1, 8'hB2, 32'hB};
        v[10] = '{1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 1'b0, 1'b1, 8'h00, 32'hB};
        v[11] = '{1'b0, 1'b1, 8'hA1, 32'hA,  1'b0, 1'b1, 1'b1, 8'hA1, 32'hA};
        v[12] = '{1'b0, 1'b1, 8'hB2, 32'hB,  1'b0, 1'b1, 1'b0, 8'hA1, 32'hA};
        v[13] = '{1'b1, 1'b1, 8'hCC, 32'hC,  1'b0, 1'b0, 1'b1, 8'h00, 32'hA};
        v[14] = '{1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 1'b0, 1'b1, 8'h00, 32'hA};
        v[15] = '{1'b0, 1'b1, 8'hFF, 32'h55, 1'b1, 1'b1, 1'b1, 8'hFF, 32'h55};
        v[16] = '{1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 1'b0, 1'b1, 8'h00, 32'h55};
        v[17] = '{1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0, 1'b1, 8'h00, 32'h55};
        v[18] = '{1'b0, 1'b1, 8'hD1, 32'hD,  1'b0, 1'b1, 1'b1, 8'hD1, 32'hD};
        v[19] = '{1'b1, 1'b0, 8'h00, 32'h0,  1'b1, 1'b0, 1'b1, 8'h00, 32'hD};
        v[20] = '{1'b1, 1'b1, 8'hE1, 32'hE,  1'b0, 1'b0, 1'b1, 8'h00, 32'hD};

        rst_i = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
`ifdef PIPE_STAGE_SKID_BUBBLE_CNT_EN
        cnt_clr_i = 1'b0;
`endif
        step();
        step();
        rst_i = 1'b0;
        chk_out("reset", 1'b0, 1'b1, 8'h00, 32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(v[i].flush, v[i].iv, v[i].ictrl, v[i].idata, v[i].ordy);
            step();
            chk_out($sformatf("vec%0d", i), v[i].e_ov, v[i].e_ir, v[i].e_ctrl, v[i].e_data);
        end

        // asynchronous reset between edges while holding one entry
        drive(1'b0, 1'b1, 8'h33, 32'h33, 1'b0);
        step();
        chk_out("pre_arst", 1'b1, 1'b1, 8'h33, 32'h33);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        chk_out("arst", 1'b0, 1'b1, 8'h00, 32'h0);
        #3 rst_i = 1'b0;
        drive(1'b0, 1'b1, 8'h44, 32'h44, 1'b1);
        step();
        chk_out("post_arst", 1'b1, 1'b1, 8'h44, 32'h44);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        step();
        chk_out("post_arst_drain", 1'b0, 1'b1, 8'h00, 32'h44);

`ifdef PIPE_STAGE_SKID_BUBBLE_CNT_EN
        cnt_clr_i = 1'b1;
        step();
        chk("bcnt_clr0", {30'b0, bubble_cnt_o}, 32'd0);
        cnt_clr_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("bcnt_sat", {30'b0, bubble_cnt_o}, 32'd3);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        chk("bcnt_clr1", {30'b0, bubble_cnt_o}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline register for the RISC-V datapath; generalises the fixed IF/ID, ID/EX and EX/MEM stage registers into one reusable stage.
- Uses a valid/ready handshake, so a downstream stall back-pressures without dropping data.
- A 2-entry skid buffer lets in_ready_o be a registered signal.
- Separates control bits, which are zeroed on flush to form a bubble, from the data payload, which is held.

Parameters:
- DATA_W, 32, width of data payload (operands, imm, instr).
- CTRL_W, 8, width of control field (RegWrite, MemRead, ...); zeroed on flush or empty.
- CNT_W, 16, bubble counter width (used only with optional feature).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  discard all held entries and the in-flight input this cycle.
- in_valid_i  in  1  upstream has an entry.
- in_ready_o  out  1  stage can accept; registered.
- in_ctrl_i  in  CTRL_W  upstream control field.
- in_data_i  in  DATA_W  upstream data payload.
- out_valid_o  out  1  stage holds an entry for downstream.
- out_ready_i  in  1  downstream accepts.
- out_ctrl_o  out  CTRL_W  control field of head entry; 0 when out_valid_o=0.
- out_data_o  out  DATA_W  data of head entry; holds last value when empty.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. All outputs come directly from registers, with no combinational in-to-out path.
- Transfers: in-transfer = in_valid_i & in_ready_o; out-transfer = out_valid_o & out_ready_i.
- State EMPTY:
  - out_valid_o=0, in_ready_o=1.
  - in_valid_i → main<=input, go to ONE.
- State ONE:
  - out_valid_o=1, in_ready_o=1.
  - out_ready_i & in_valid_i → main<=input, stay ONE.
  - out_ready_i only → go to EMPTY, main ctrl<=0.
  - in_valid_i only → skid<=input, go to TWO.
  - neither → hold.
- State TWO:
  - out_valid_o=1, in_ready_o=0.
  - out_ready_i → main<=skid, skid ctrl<=0, go to ONE.
  - else hold. in_valid_i is ignored.
- Latency and throughput:
  - Minimum latency is 1 cycle from in-transfer to out_valid_o.
  - Full throughput is 1 entry/cycle when out_ready_i is held high.
  - Order is strictly FIFO and no entry is ever duplicated.
- Flush (highest priority over all transitions):
  - Next state is EMPTY.
  - Main and skid ctrl are set to 0; data registers are unchanged.
  - An in-transfer or out-transfer in the flush cycle completes as a handshake, but the input is discarded.
  - in_ready_o is 1 in the cycle after the flush.
- Reset (asynchronous, any time, including mid-transfer):
  - State EMPTY, out_valid_o=0, in_ready_o=1, out_ctrl_o=0, out_data_o=0, skid=0.
- Invariant: out_ctrl_o == 0 whenever out_valid_o == 0, so a downstream consumer that reads ctrl without checking valid sees a bubble.
- Simultaneous flush_i and rst_i: reset wins.
- No arithmetic on the payload; widths pass through unchanged.

Optional Feature:
- Macro: PIPE_STAGE_SKID_BUBBLE_CNT_EN.
- When defined:
  - Adds input cnt_clr_i (1 bit) and output bubble_cnt_o (CNT_W).
  - Counter increments on every clock edge where out_valid_o=0 or (out_valid_o=1 & out_ready_i=0).
  - Saturates at 2^CNT_W-1.
  - cnt_clr_i sets it to 0 next cycle and takes priority over increment.
  - Reset value 0.
- When undefined: the ports and counter logic do not exist; all other behaviour is identical.

Test Plan:
- Streaming: out_ready_i=1 held; push ctrl=0x11..0x15 with data=1..5 on consecutive cycles. Each appears on the outputs exactly 1 cycle later, out_valid_o continuous, in_ready_o stays 1.
- Back-pressure: fill with A (data=0xA), then B (0xB) while out_ready_i=0. in_ready_o=0 on the cycle after B is accepted. Raise out_ready_i: outputs A then B in order, in_ready_o returns to 1, with no loss and no duplicate.
- Flush in TWO: state holds A and B; assert flush_i with in_valid_i=1 and data=0xC. Next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1, and 0xC never appears on the outputs.
- Async reset mid-operation: assert rst_i between clock edges while in ONE. out_valid_o=0, out_ctrl_o=0, out_data_o=0 and in_ready_o=1 immediately; first push after release has 1-cycle latency.
- Empty invariant: drain the stage with ctrl=0xFF. out_ctrl_o=0x00 while out_valid_o=0, and out_data_o keeps the last value.
- With PIPE_STAGE_SKID_BUBBLE_CNT_EN, CNT_W=2: hold the stage empty 5 cycles. bubble_cnt_o reads 3 (saturated); pulse cnt_clr_i and it reads 0 the next cycle.
